// File: rtl/pico_pkg.sv
// Shared definitions for the picoMIPS I/O sequencer.
//   - state_t      : sequencer FSM states
//   - PICO_DATA_W  : default width of the switch data and CPU I/O bus
//   - PICO_LED_W   : default number of LED outputs
//   - is_wait()    : true in the states that need operator action
package pico_pkg;

  localparam int PICO_DATA_W = 8;
  localparam int PICO_LED_W  = 7;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2,
    HALT    = 2'd3
  } state_t;

  function automatic logic is_wait(input state_t s);
    return (s == WAIT_HI) || (s == WAIT_LO);
  endfunction

endpackage

// File: rtl/pico_debounce.sv
// Debouncer for the asynchronous SW[8] handshake switch.
// Ports:
//   clk     : clock
//   srst    : synchronous active-high reset
//   raw_i   : raw switch level, asynchronous to clk
//   db_o    : debounced level
//   rise_o  : one-cycle strobe in the cycle whose closing edge sets db 0->1
//   fall_o  : one-cycle strobe in the cycle whose closing edge sets db 1->0
// The level changes only after DB_CYCLES consecutive synchronised samples
// disagree with it; any agreeing sample restarts the count.
module pico_debounce
  import pico_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             db_q;
  logic             db_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             flip;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    flip  = 1'b0;
    if (sync2_q != db_q) begin
      // This sample is the DB_CYCLES-th disagreeing one: flip the level.
      if (cnt_q == CNT_LAST) begin
        flip  = 1'b1;
        cnt_d = '0;
        db_d  = ~db_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes lead db by one cycle so a consumer can register alongside db.
  assign db_o   = db_q;
  assign rise_o = flip & ~db_q;
  assign fall_o = flip & db_q;

endmodule

// File: rtl/pico_io_sequencer.sv
// picoMIPS execution sequencer and switch/LED sharing logic.
// Ports:
//   fastclk      : board clock
//   reset        : synchronous active-high reset
//   sw_data      : raw data switches SW[7:0]
//   sw_ready     : raw handshake switch SW[8] (asynchronous)
//   cpu_in_req   : CPU is executing an input instruction
//   cpu_out_we   : CPU output-write strobe
//   cpu_out_data : CPU output value
//   cpu_halt     : CPU reached a halt instruction
//   cpu_en       : single-cycle CPU clock enable
//   cpu_in_data  : captured switch byte for the CPU
//   cpu_in_valid : cpu_in_data is valid for the pending input instruction
//   led          : registered LED drive
//   busy_wait    : operator action required (WAIT_HI / WAIT_LO)
module pico_io_sequencer
  import pico_pkg::*;
#(
  parameter int DIV_W     = 2,
  parameter int DB_CYCLES = 4,
  parameter int DATA_W    = PICO_DATA_W,
  parameter int LED_W     = PICO_LED_W
) (
  input  logic              fastclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_ready,
  input  logic              cpu_in_req,
  input  logic              cpu_out_we,
  input  logic [DATA_W-1:0] cpu_out_data,
  input  logic              cpu_halt,
  output logic              cpu_en,
  output logic [DATA_W-1:0] cpu_in_data,
  output logic              cpu_in_valid,
  output logic [LED_W-1:0]  led,
  output logic              busy_wait
);

  state_t              state_q;
  state_t              state_d;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    div_d;
  logic [DATA_W-1:0]   in_data_q;
  logic [DATA_W-1:0]   in_data_d;
  logic                in_valid_q;
  logic                in_valid_d;
  logic [LED_W-1:0]    led_q;
  logic [LED_W-1:0]    led_d;
  logic                en;
  logic                slot;
  logic                db_level;
  logic                db_rise;
  logic                db_fall;

  pico_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk    (fastclk),
    .srst   (reset),
    .raw_i  (sw_ready),
    .db_o   (db_level),
    .rise_o (db_rise),
    .fall_o (db_fall)
  );

  assign slot = &div_q;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    in_data_d  = in_data_q;
    in_valid_d = in_valid_q;
    led_d      = led_q;
    en         = 1'b0;

    unique case (state_q)
      RUN: begin
        div_d = div_q + 1'b1;
        if (slot) begin
          // An input request already satisfied by the handshake is let
          // through, so the resuming pulse does not re-trigger a stall.
          if (cpu_in_req && !in_valid_q) begin
            state_d = WAIT_HI;
          end else if (cpu_halt && !cpu_in_req) begin
            state_d = HALT;
          end else begin
            en = 1'b1;
          end
        end
        // Leaving RUN restarts the divider so the first slot after
        // resuming is a full period away.
        if (state_d != RUN) begin
          div_d = '0;
        end
      end
      WAIT_HI: begin
        // Only a genuine low->high transition captures; a level already
        // high on entry must first be released.
        if (db_rise) begin
          in_data_d = sw_data;
          state_d   = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (db_fall) begin
          in_valid_d = 1'b1;
          state_d    = RUN;
        end
      end
      HALT: begin
      end
      default: begin
        state_d = RUN;
        div_d   = '0;
      end
    endcase

    if (en) begin
      in_valid_d = 1'b0;
      if (cpu_out_we) begin
        led_d = cpu_out_data[LED_W-1:0];
      end
    end
  end

  always_ff @(posedge fastclk) begin
    if (reset) begin
      state_q    <= RUN;
      div_q      <= '0;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      in_data_q  <= in_data_d;
      in_valid_q <= in_valid_d;
      led_q      <= led_d;
    end
  end

  // The enable is masked while reset is held so no CPU step escapes it.
  assign cpu_en       = en & ~reset;
  assign cpu_in_data  = in_data_q;
  assign cpu_in_valid = in_valid_q;
  assign led          = led_q;
  assign busy_wait    = is_wait(state_q);

  // The debounced level itself is not needed here, only its edges; the
  // upper output bits have no LED to drive.
  logic unused_db;
  assign unused_db = db_level;

  generate
    if (DATA_W > LED_W) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^cpu_out_data[DATA_W-1:LED_W];
    end
  endgenerate

endmodule

// File: tb/tb_pico_io_sequencer.sv
module tb_pico_io_sequencer;

  logic       fastclk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw_data = 8'h00;
  logic       sw_ready = 1'b0;
  logic       cpu_in_req = 1'b0;
  logic       cpu_out_we = 1'b0;
  logic [7:0] cpu_out_data = 8'h00;
  logic       cpu_halt = 1'b0;
  logic       cpu_en;
  logic [7:0] cpu_in_data;
  logic       cpu_in_valid;
  logic [6:0] led;
  logic       busy_wait;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_din_q[$];
  logic [6:0] exp_led_q[$];

  pico_io_sequencer #(
    .DIV_W     (2),
    .DB_CYCLES (4),
    .DATA_W    (8),
    .LED_W     (7)
  ) dut (
    .fastclk      (fastclk),
    .reset        (reset),
    .sw_data      (sw_data),
    .sw_ready     (sw_ready),
    .cpu_in_req   (cpu_in_req),
    .cpu_out_we   (cpu_out_we),
    .cpu_out_data (cpu_out_data),
    .cpu_halt     (cpu_halt),
    .cpu_en       (cpu_en),
    .cpu_in_data  (cpu_in_data),
    .cpu_in_valid (cpu_in_valid),
    .led          (led),
    .busy_wait    (busy_wait)
  );

  always #5 fastclk = ~fastclk;

  task automatic tick();
    @(posedge fastclk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_slot(input string tag);
    int n;
    n = 0;
    while (cpu_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, cpu_en}, 32'd1);
  endtask

  logic [7:0] din_exp;
  logic [6:0] led_exp;

  initial begin
    // Reset held for two edges.
    tick();
    tick();
    chk("rst_led", {25'd0, led}, 32'd0);
    chk("rst_valid", {31'd0, cpu_in_valid}, 32'd0);
    chk("rst_din", {24'd0, cpu_in_data}, 32'd0);
    chk("rst_busy", {31'd0, busy_wait}, 32'd0);
    chk("rst_en", {31'd0, cpu_en}, 32'd0);
    reset = 1'b0;
    $display("reset released");

    // Enable on cycles 4, 8, 12 after release.
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("div_c%0d", c), {31'd0, cpu_en}, (c % 4 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    $display("divider pattern checked");

    // LED write during an enable pulse, truncated to 7 bits.
    wait_slot("slot_for_led");
    cpu_out_we = 1'b1;
    cpu_out_data = 8'hA5;
    exp_led_q.push_back(7'h25);
    tick();
    cpu_out_we = 1'b0;
    led_exp = exp_led_q.pop_front();
    chk("led_write", {25'd0, led}, {25'd0, led_exp});
    $display("led write A5 -> %h", led);

    // Same write without an enable pulse: no change.
    chk("led_noen_en", {31'd0, cpu_en}, 32'd0);
    cpu_out_we = 1'b1;
    cpu_out_data = 8'h5A;
    tick();
    cpu_out_we = 1'b0;
    chk("led_noen", {25'd0, led}, 32'h25);
    $display("led write without enable, led=%h", led);

    // Input handshake.
    wait_slot("slot_before_in");
    tick();
    tick();
    tick();
    cpu_in_req = 1'b1;
    sw_data = 8'h3C;
    tick();
    chk("stall_en", {31'd0, cpu_en}, 32'd0);
    chk("stall_busy_run", {31'd0, busy_wait}, 32'd0);
    tick();
    chk("wait_hi_busy", {31'd0, busy_wait}, 32'd1);
    sw_ready = 1'b1;
    exp_din_q.push_back(8'h3C);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("hs_hi_en%0d", i), {31'd0, cpu_en}, 32'd0);
      chk($sformatf("hs_hi_busy%0d", i), {31'd0, busy_wait}, 32'd1);
      if (i == 5) chk("din_early", {24'd0, cpu_in_data}, 32'd0);
      if (i == 6) begin
        din_exp = exp_din_q.pop_front();
        chk("din_capture", {24'd0, cpu_in_data}, {24'd0, din_exp});
      end
    end
    $display("press captured din=%h", cpu_in_data);
    sw_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("hs_lo_en%0d", i), {31'd0, cpu_en}, 32'd0);
      chk($sformatf("hs_lo_valid%0d", i), {31'd0, cpu_in_valid}, (i == 6) ? 32'd1 : 32'd0);
      chk($sformatf("hs_lo_busy%0d", i), {31'd0, busy_wait}, (i == 6) ? 32'd0 : 32'd1);
    end
    $display("release seen valid=%0b", cpu_in_valid);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) tick();
      chk($sformatf("resume_en%0d", k), {31'd0, cpu_en}, (k == 4) ? 32'd1 : 32'd0);
    end
    tick();
    chk("valid_clear", {31'd0, cpu_in_valid}, 32'd0);
    chk("no_retrigger_en", {31'd0, cpu_en}, 32'd0);
    $display("resume pulse consumed valid=%0b", cpu_in_valid);

    // Short glitch in WAIT_HI must not capture.
    begin
      int n;
      n = 0;
      while (busy_wait !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
    end
    chk("glitch_enter_wait", {31'd0, busy_wait}, 32'd1);
    sw_data = 8'hC3;
    sw_ready = 1'b1;
    tick();
    tick();
    tick();
    sw_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("glitch_busy%0d", i), {31'd0, busy_wait}, 32'd1);
    end
    chk("glitch_din", {24'd0, cpu_in_data}, 32'h3C);
    $display("glitch ignored din=%h", cpu_in_data);

    // Reset during WAIT_LO.
    sw_data = 8'h3C;
    sw_ready = 1'b1;
    exp_din_q.push_back(8'h3C);
    for (int i = 1; i <= 6; i++) tick();
    din_exp = exp_din_q.pop_front();
    chk("wlo_din", {24'd0, cpu_in_data}, {24'd0, din_exp});
    chk("wlo_busy", {31'd0, busy_wait}, 32'd1);
    tick();
    tick();
    reset = 1'b1;
    sw_ready = 1'b0;
    cpu_in_req = 1'b0;
    tick();
    chk("midrst_busy", {31'd0, busy_wait}, 32'd0);
    chk("midrst_din", {24'd0, cpu_in_data}, 32'd0);
    chk("midrst_valid", {31'd0, cpu_in_valid}, 32'd0);
    chk("midrst_led", {25'd0, led}, 32'd0);
    reset = 1'b0;
    $display("reset in WAIT_LO busy=%0b din=%h", busy_wait, cpu_in_data);

    // Halt holds LEDs and stops enables until reset.
    wait_slot("slot_before_halt");
    cpu_out_we = 1'b1;
    cpu_out_data = 8'hA5;
    exp_led_q.push_back(7'h25);
    tick();
    cpu_out_we = 1'b0;
    led_exp = exp_led_q.pop_front();
    chk("led_before_halt", {25'd0, led}, {25'd0, led_exp});
    tick();
    tick();
    cpu_halt = 1'b1;
    tick();
    chk("halt_slot_en", {31'd0, cpu_en}, 32'd0);
    cpu_out_we = 1'b1;
    cpu_out_data = 8'hFF;
    for (int i = 1; i <= 50; i++) begin
      tick();
      chk($sformatf("halt_en%0d", i), {31'd0, cpu_en}, 32'd0);
      chk($sformatf("halt_led%0d", i), {25'd0, led}, {25'd0, led_exp});
    end
    $display("halt held led=%h", led);
    reset = 1'b1;
    cpu_halt = 1'b0;
    cpu_out_we = 1'b0;
    tick();
    chk("halt_rst_led", {25'd0, led}, 32'd0);
    reset = 1'b0;
    wait_slot("resume_after_halt");
    $display("pulsing restored after halt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pico_io_sequencer.md
Name: pico_io_sequencer

Overview:
- Sequences the picoMIPS core's execution and shares the board switches and LEDs with it.
- Generates a divided run-enable for the CPU.
- Stalls the CPU on input-instruction requests until the operator completes a debounced SW[8] press/release handshake, then presents the captured SW[7:0] byte.
- Latches CPU output writes onto the 7 LEDs.
- Sits between the top-level board pins and the CPU core.

Parameters:
- DIV_W, 2, width of the run-enable divider; the CPU enable fires once every 2**DIV_W cycles.
- DB_CYCLES, 4, consecutive stable synchronised samples required to change the debounced sw_ready level.
- DATA_W, 8, width of the switch data and CPU I/O bus.
- LED_W, 7, number of LED outputs.

Ports:
- fastclk  input  1  board clock; the single clock for the block.
- reset  input  1  synchronous, active-high reset.
- sw_data  input  DATA_W  raw data switches (SW[7:0]).
- sw_ready  input  1  raw handshake switch (SW[8]), asynchronous to fastclk.
- cpu_in_req  input  1  CPU is executing an input instruction.
- cpu_out_we  input  1  CPU output-write strobe.
- cpu_out_data  input  DATA_W  CPU output value.
- cpu_halt  input  1  CPU has reached a halt instruction.
- cpu_en  output  1  single-cycle CPU clock enable.
- cpu_in_data  output  DATA_W  captured switch byte presented to the CPU.
- cpu_in_valid  output  1  cpu_in_data is valid for the pending input instruction.
- led  output  LED_W  registered LED drive.
- busy_wait  output  1  high in WAIT_HI or WAIT_LO (operator action required).

Behaviour:
- Reset (synchronous, active-high): all outputs 0; state RUN; divider, synchroniser, debounce counter and debounced level all 0. Reset asserted in any state, including mid-handshake, returns the block to this condition on the next edge.
- Synchroniser: sw_ready passes through 2 flops. The debounced level db flips only after DB_CYCLES consecutive synchronised samples differ from db; any agreeing sample clears the debounce counter.
- Debounce latency from a clean raw edge to db changing is 2+DB_CYCLES cycles.
- Divider: runs only in RUN, counting 0..2**DIV_W-1 and wrapping. A slot occurs when the divider equals all-ones.
- The divider is cleared when entering any non-RUN state, so the first slot after resuming occurs 2**DIV_W cycles later.
- RUN:
  - At a slot with cpu_in_req=1 and cpu_in_valid=0, cpu_en stays 0 and the next state is WAIT_HI.
  - At a slot with cpu_halt=1 and cpu_in_req=0, cpu_en stays 0 and the next state is HALT.
  - Otherwise, at a slot, cpu_en=1 for exactly one cycle.
- WAIT_HI: on db rising (0→1), sw_data is registered into cpu_in_data (sampled raw in the same cycle db flips); next state WAIT_LO.
- WAIT_LO: on db falling, cpu_in_valid is set to 1; next state RUN.
- cpu_in_valid clears on the cycle following the cpu_en pulse that consumes it. That pulse is issued even though cpu_in_req is still high, so there is no re-trigger.
- HALT: cpu_en is held 0 and led holds its value; only reset exits HALT.
- Output latching: when cpu_en=1 and cpu_out_we=1, led <= cpu_out_data[LED_W-1:0] on the next edge (truncation; upper bits are dropped).
- Simultaneous cpu_in_req and cpu_out_we at a stalled slot: no LED write, because cpu_en=0. The write is performed on the resuming pulse.
- Simultaneous cpu_in_req and cpu_halt: cpu_in_req has priority.
- If db is already 1 on entering WAIT_HI, the block waits for a full low→high transition: release, then press.

Decomposition:
- Shared package pico_pkg:
  - typedef state_t enum {RUN, WAIT_HI, WAIT_LO, HALT};
  - default-constant localparams for DATA_W and LED_W.
- One natural sub-module, pico_debounce: 2-flop synchroniser plus DB_CYCLES stability counter. It outputs db and a one-cycle rise/fall pulse.
- FSM, divider and LED register remain in pico_io_sequencer.

Test Plan:
- Reset held 2 cycles, then released with cpu_in_req=0 → led=0, cpu_in_valid=0; cpu_en pulses on the 4th, 8th and 12th cycle after release (DIV_W=2).
- cpu_out_we=1, cpu_out_data=8'hA5 during a cpu_en pulse → led=7'h25 one cycle later. The same stimulus with cpu_en=0 → led unchanged.
- cpu_in_req=1 at a slot, sw_data=8'h3C, then sw_ready high 10 cycles, then low 10 cycles:
  - busy_wait=1 and no cpu_en during the handshake;
  - cpu_in_data=8'h3C 6 cycles after the rise;
  - cpu_in_valid=1 6 cycles after the fall;
  - exactly one cpu_en 4 cycles after returning to RUN;
  - cpu_in_valid=0 the following cycle.
- In WAIT_HI, sw_ready glitches high for 3 cycles, then low → no capture, state stays WAIT_HI, cpu_in_data unchanged.
- Reset asserted during WAIT_LO with cpu_in_data=8'h3C → next cycle: state RUN, cpu_in_data=0, cpu_in_valid=0, led=0.
- cpu_halt=1 at a slot → cpu_en stays 0 for 50 cycles and led holds 7'h25; a subsequent reset restores pulsing.
